// File: rtl/ast_dmx_mcast.sv
`default_nettype none
// ============================================================================
// Module  : ast_dmx_mcast
// Brief   : Avalon-ST 1-to-TX_DIR multicast demultiplexer. A direction mask
//           sampled on the SOP beat replicates the packet to every selected
//           output through a per-output registered stage. Zero-mask packets
//           are dropped and counted; protocol errors are counted.
// Revision: 1.0 - initial release
// ============================================================================
module ast_dmx_mcast #(
    parameter int DATA_WIDTH    = 64,
    parameter int CHANNEL_WIDTH = 8,
    parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH/8),
    parameter int TX_DIR        = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [TX_DIR-1:0]        dir_mask_i,
    input  logic [DATA_WIDTH-1:0]    ast_data_i,
    input  logic                     ast_startofpacket_i,
    input  logic                     ast_endofpacket_i,
    input  logic                     ast_valid_i,
    input  logic [EMPTY_WIDTH-1:0]   ast_empty_i,
    input  logic [CHANNEL_WIDTH-1:0] ast_channel_i,
    output logic                     ast_ready_o,
    output logic [DATA_WIDTH-1:0]    ast_data_o          [TX_DIR],
    output logic [TX_DIR-1:0]        ast_startofpacket_o,
    output logic [TX_DIR-1:0]        ast_endofpacket_o,
    output logic [TX_DIR-1:0]        ast_valid_o,
    output logic [EMPTY_WIDTH-1:0]   ast_empty_o         [TX_DIR],
    output logic [CHANNEL_WIDTH-1:0] ast_channel_o       [TX_DIR],
    input  logic [TX_DIR-1:0]        ast_ready_i,
    output logic [CNT_WIDTH-1:0]     drop_cnt_o,
    output logic [CNT_WIDTH-1:0]     err_cnt_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FWD  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]        state;
    logic [TX_DIR-1:0] mask_q;
    logic [TX_DIR-1:0] mask_eff;
    logic [TX_DIR-1:0] slot_free;
    logic [TX_DIR-1:0] load;
    logic              in_idle;
    logic              in_fwd;
    logic              accept;
    logic              fwd_beat;
    logic              drop_evt;
    logic              err_evt;

    // Effective mask, lock-step backpressure and per-beat event decode
    always_comb begin
        in_idle   = (state == ST_IDLE);
        in_fwd    = (state == ST_FWD);
        mask_eff  = in_idle ? dir_mask_i : mask_q;
        slot_free = ~ast_valid_o | ast_ready_i;
        case (state)
            // A zero mask reduces to 1 so dropped packets never stall
            ST_IDLE: ast_ready_o = ast_startofpacket_i ? &(slot_free | ~mask_eff) : 1'b1;
            ST_FWD:  ast_ready_o = &(slot_free | ~mask_q);
            default: ast_ready_o = 1'b1;
        endcase
        accept   = ast_valid_i & ast_ready_o;
        // Only SOP beats in IDLE and every beat in FWD reach the outputs
        fwd_beat = in_fwd | (in_idle & ast_startofpacket_i);
        load     = mask_eff & {TX_DIR{accept & fwd_beat}};
        drop_evt = accept & in_idle & ast_startofpacket_i & (dir_mask_i == '0);
        err_evt  = accept & ((in_idle & ~ast_startofpacket_i) |
                             (in_fwd  &  ast_startofpacket_i));
    end

    // Packet-level state and mask latched on a multi-beat SOP
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state  <= ST_IDLE;
            mask_q <= '0;
        end else if (accept) begin
            case (state)
                ST_IDLE: begin
                    if (ast_startofpacket_i && !ast_endofpacket_i) begin
                        if (dir_mask_i != '0) begin
                            state  <= ST_FWD;
                            mask_q <= dir_mask_i;
                        end else begin
                            state <= ST_DROP;
                        end
                    end
                end
                ST_FWD:  if (ast_endofpacket_i) state <= ST_IDLE;
                ST_DROP: if (ast_endofpacket_i) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Per-output registered stage: load a replicated beat or retire the held one
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ast_valid_o         <= '0;
            ast_startofpacket_o <= '0;
            ast_endofpacket_o   <= '0;
            for (int j = 0; j < TX_DIR; j++) begin
                ast_data_o[j]    <= '0;
                ast_empty_o[j]   <= '0;
                ast_channel_o[j] <= '0;
            end
        end else begin
            for (int j = 0; j < TX_DIR; j++) begin
                if (load[j]) begin
                    ast_valid_o[j]         <= 1'b1;
                    ast_startofpacket_o[j] <= ast_startofpacket_i;
                    ast_endofpacket_o[j]   <= ast_endofpacket_i;
                    ast_data_o[j]          <= ast_data_i;
                    ast_empty_o[j]         <= ast_empty_i;
                    ast_channel_o[j]       <= ast_channel_i;
                end else if (ast_ready_i[j]) begin
                    ast_valid_o[j] <= 1'b0;
                end
            end
        end
    end

    // Saturating drop and protocol-error counters
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            drop_cnt_o <= '0;
            err_cnt_o  <= '0;
        end else begin
            if (drop_evt && (drop_cnt_o != '1)) drop_cnt_o <= drop_cnt_o + 1'b1;
            if (err_evt  && (err_cnt_o  != '1)) err_cnt_o  <= err_cnt_o  + 1'b1;
        end
    end

endmodule
`default_nettype wire
